sha256_compress: RTL and testbench
==================================

# sha256_compress

Parametrised, multi-cycle SHA-256 compression engine that processes one pre-padded 512-bit message block per transaction and returns the 256-bit chaining value. It iterates the FIPS 180-4 round using the existing Ch, Maj, SIGMA0/1 and sigma0/1 function modules, and supports a configurable number of rounds per clock. It sits between the block/nonce formatter and the double-hash and target-compare logic in the uPcoin datapath.

## Interface
- UNROLL, default 1: rounds per clock; legal values 1, 2, 4, 8. Any other value is an elaboration error.
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  block_i (and hash_in) valid
- in_ready  output  1  engine idle, can accept a block
- block_i  input  512  padded block; W0 = block_i[511:480] … W15 = block_i[31:0], big-endian words
- hash_in  input  256  initial chaining value, H0 = [255:224]; present only with SHA256_MIDSTATE_EN
- out_valid  output  1  hash_out valid
- out_ready  input  1  consumer accepts hash_out
- hash_out  output  256  result, H0 = [255:224]

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. When in_valid & in_ready: latch the 16-word schedule window from block_i, latch H_init (hash_in or IV), load a..h = H_init, set round counter t = 0, go to RUN.
- RUN: each cycle, apply UNROLL chained rounds t..t+UNROLL-1. Rounds 0–15 use the window words. Later words use W_t = sigma1(W_t-2) + W_t-7 + sigma0(W_t-15) + W_t-16. The window shifts by UNROLL words per cycle. t advances by UNROLL.
- Leave RUN on the cycle that completes round 63. At that edge, hash_out[i] = H_init[i] + {a..h}[i] and out_valid is set. Go to DONE.
- DONE: hold hash_out and out_valid until out_ready = 1, then clear out_valid and return to IDLE.
- in_ready = 1 only in IDLE. in_valid is ignored in RUN and DONE. block_i and hash_in are sampled only at acceptance.
- All additions are mod 2^32 with carries discarded. Constants K[0..63] and IV are as specified in FIPS 180-4.
- Reset, including mid-RUN or mid-DONE: go to IDLE and abandon the operation. in_ready = 1, out_valid = 0, hash_out = 0, t = 0, working registers = 0.

## Timing
- The acceptance edge is cycle 0. The first round executes on cycle 1. out_valid rises at the end of cycle 64/UNROLL, giving latency 64/UNROLL + 1 cycles from acceptance to out_valid visible. Examples: UNROLL=1 → 65, UNROLL=4 → 17.
- Minimum interval between accepted blocks is 64/UNROLL + 2 cycles: this is DONE plus IDLE with out_ready held high.
- There are no combinational paths from in_valid to in_ready or from out_ready to out_valid. All outputs are registered except in_ready, which is decoded from the state register.

## Configuration
- SHA256_MIDSTATE_EN defined: the hash_in port exists. H_init = hash_in latched at acceptance, which supports multi-block messages and Bitcoin midstate reuse.
- SHA256_MIDSTATE_EN undefined: there is no hash_in port, and H_init is the FIPS 180-4 IV (6a09e667 … 5be0cd19). Only single-block messages are supported.

## Structure
- Package sha256_pkg holds:
  - typedef word_t (logic [31:0]);
  - state enum state_t {IDLE, RUN, DONE};
  - localparam K[64] array;
  - localparam IV[8].
- Sub-module sha256_round is combinational. It takes a..h, W_t and K_t and returns the next a..h, built from Ch/Maj/SIGMA0/SIGMA1. UNROLL copies are chained through a generate loop.
- The schedule expansion instantiates sigma0/sigma1 per unrolled word.

## Test plan
- Message "abc": block_i = {32'h61626380, 416'h0, 64'h18}, IV. Expect hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid exactly 65 cycles after acceptance for UNROLL=1 and 17 cycles for UNROLL=4.
- Empty message: block_i = {32'h80000000, 480'h0}. Expect e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (SHA256_MIDSTATE_EN): block 1 with hash_in = IV, then block 2 with hash_in = the block-1 result. Final hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid, and pulse in_valid with a different block meanwhile. Expect hash_out stable, in_ready = 0, and the second block not accepted. Expect acceptance on the cycle after out_ready = 1 is followed by IDLE.
- Reset mid-RUN: assert reset_n = 0 at round 30 of an "abc" run. Expect in_ready = 1, out_valid = 0 and hash_out = 0 on the next cycle. A subsequent empty-message block yields the correct empty-message hash.
- UNROLL sweep 1/2/4/8 on "abc": identical hash_out, with latencies 65/33/17/9.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, FIPS 180-4 constants and the SHA-256 bit-mixing functions
// used by the compression engine and its round sub-module.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Chaining-value layout used on every 256-bit bus: H0/a in the top word.
  localparam logic [255:0] IV_FLAT = {IV[0], IV[1], IV[2], IV[3],
                                      IV[4], IV[5], IV[6], IV[7]};

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round; state bus packs a..h with a in [255:224].
// Chained UNROLL times per clock by sha256_compress.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_i,
  input  word_t        w_i,
  input  word_t        k_i,
  output logic [255:0] st_o
);

  word_t a, b, c, d, e, f, g, h;
  word_t t1, t2;

  assign {a, b, c, d, e, f, g, h} = st_i;

  assign t1   = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
  assign t2   = big_sigma0(a) + maj(a, b, c);
  assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: multi-cycle SHA-256 block compression, UNROLL rounds per clock, result after
// 64/UNROLL+1 cycles and held until out_ready. Defining SHA256_MIDSTATE_EN adds the hash_in port.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_i,
`ifdef SHA256_MIDSTATE_EN
  input  logic [255:0] hash_in,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] hash_out
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_compress: UNROLL must be 1, 2, 4 or 8");
  end

  state_t       state_q, state_d;
  logic [5:0]   t_q, t_d;
  word_t [15:0] w_q, w_d;
  logic [255:0] wk_q, wk_d;
  logic [255:0] hash_q, hash_d;
  logic         out_valid_q, out_valid_d;

  logic [255:0] h_init;
  logic [255:0] load_val;
  logic [255:0] final_sum;
  logic         last_round;

  // ext[0..15] is the live window (ext[0] = W_t); ext[16..] are the words expanded this cycle.
  word_t        ext   [16+UNROLL];
  logic [255:0] chain [UNROLL+1];

`ifdef SHA256_MIDSTATE_EN
  logic [255:0] hinit_q, hinit_d;
  assign h_init   = hinit_q;
  assign load_val = hash_in;
`else
  assign h_init   = IV_FLAT;
  assign load_val = IV_FLAT;
`endif

  for (genvar j = 0; j < 16; j++) begin : g_win
    assign ext[j] = w_q[j];
  end

  for (genvar u = 0; u < UNROLL; u++) begin : g_exp
    assign ext[16+u] = small_sigma1(ext[14+u]) + ext[9+u]
                     + small_sigma0(ext[1+u]) + ext[u];
  end

  assign chain[0] = wk_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
    sha256_round u_round (
      .st_i (chain[u]),
      .w_i  (ext[u]),
      .k_i  (K[t_q + 6'(u)]),
      .st_o (chain[u+1])
    );
  end

  assign last_round = (t_q == 6'(64 - UNROLL));

  always_comb begin
    final_sum = '0;
    for (int i = 0; i < 8; i++) begin
      final_sum[32*i +: 32] = h_init[32*i +: 32] + chain[UNROLL][32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    w_d         = w_q;
    wk_d        = wk_q;
    hash_d      = hash_q;
    out_valid_d = out_valid_q;
`ifdef SHA256_MIDSTATE_EN
    hinit_d     = hinit_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int j = 0; j < 16; j++) begin
            w_d[j] = block_i[511-32*j -: 32];
          end
          wk_d    = load_val;
          t_d     = '0;
          state_d = RUN;
`ifdef SHA256_MIDSTATE_EN
          hinit_d = hash_in;
`endif
        end
      end
      RUN: begin
        for (int j = 0; j < 16; j++) begin
          w_d[j] = ext[j+UNROLL];
        end
        wk_d = chain[UNROLL];
        // Wraps back to 0 on the final step, ready for the next block.
        t_d  = t_q + 6'(UNROLL);
        if (last_round) begin
          hash_d      = final_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      w_q         <= '0;
      wk_q        <= '0;
      hash_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef SHA256_MIDSTATE_EN
      hinit_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      w_q         <= w_d;
      wk_q        <= wk_d;
      hash_q      <= hash_d;
      out_valid_q <= out_valid_d;
`ifdef SHA256_MIDSTATE_EN
      hinit_q     <= hinit_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign hash_out  = hash_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: known-answer hashes, latency, backpressure,
// mid-run reset and an UNROLL 2/4/8 sweep against an UNROLL=1 reference instance.
module tb_sha256_compress;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_HASH  =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_HASH =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam int BUDGET = 200;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block_i;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] hash_out;

  logic         sw_in_valid;
  logic [511:0] sw_block;
  logic         sw_out_ready;
  logic [2:0]   sw_in_ready;
  logic [2:0]   sw_out_valid;
  logic [255:0] sw_hash [3];

`ifdef SHA256_MIDSTATE_EN
  localparam logic [255:0] IV_C =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {448'h0, 64'h1c0};
  localparam logic [255:0] TWO_HASH =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  logic [255:0] hash_in;
`endif

  always #5 clk = ~clk;

  sha256_compress #(.UNROLL(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block_i   (block_i),
`ifdef SHA256_MIDSTATE_EN
    .hash_in   (hash_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hash_out  (hash_out)
  );

  for (genvar k = 0; k < 3; k++) begin : g_sw
    sha256_compress #(.UNROLL(2 << k)) u_sw (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[k]),
      .block_i   (sw_block),
`ifdef SHA256_MIDSTATE_EN
      .hash_in   (IV_C),
`endif
      .out_valid (sw_out_valid[k]),
      .out_ready (sw_out_ready),
      .hash_out  (sw_hash[k])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call right after the acceptance edge; lat counts that edge as cycle 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send(input logic [511:0] blk, output int lat);
    block_i  = blk;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int           lat;
  int           cyc;
  int           sw_lat [3];
  logic [255:0] sw_res [3];
  logic [255:0] held;

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    block_i      = '0;
    out_ready    = 1'b0;
    sw_in_valid  = 1'b0;
    sw_block     = '0;
    sw_out_ready = 1'b0;
`ifdef SHA256_MIDSTATE_EN
    hash_in      = IV_C;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_hash_out", hash_out, 256'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // UNROLL sweep on "abc": all three instances accept on the same edge.
    chk("sw_in_ready", 256'(sw_in_ready), 256'(3'b111));
    sw_block    = ABC_BLK;
    sw_in_valid = 1'b1;
    @(posedge clk); #1;
    sw_in_valid = 1'b0;
    cyc = 1;
    for (int k = 0; k < 3; k++) begin
      sw_lat[k] = 0;
      sw_res[k] = '0;
    end
    while ((sw_lat[0] == 0 || sw_lat[1] == 0 || sw_lat[2] == 0) && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (sw_out_valid[k] && sw_lat[k] == 0) begin
          sw_lat[k] = cyc;
          sw_res[k] = sw_hash[k];
        end
      end
    end
    chk("sw_u2_lat", 256'(sw_lat[0]), 256'(33));
    chk("sw_u4_lat", 256'(sw_lat[1]), 256'(17));
    chk("sw_u8_lat", 256'(sw_lat[2]), 256'(9));
    chk("sw_u2_hash", sw_res[0], ABC_HASH);
    chk("sw_u4_hash", sw_res[1], ABC_HASH);
    chk("sw_u8_hash", sw_res[2], ABC_HASH);

    // "abc" on the UNROLL=1 instance.
    send(ABC_BLK, lat);
    chk("abc_lat", 256'(lat), 256'(65));
    chk("abc_hash", hash_out, ABC_HASH);
    drain();
    chk("abc_drain_valid", 256'(out_valid), 256'(0));
    chk("abc_drain_ready", 256'(in_ready), 256'(1));

    // Empty message, then hold the result while a second block is offered.
    send(EMPTY_BLK, lat);
    chk("empty_lat", 256'(lat), 256'(65));
    chk("empty_hash", hash_out, EMPTY_HASH);
    held     = hash_out;
    block_i  = ABC_BLK;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      @(posedge clk); #1;
      chk("bp_hash_stable", hash_out, held);
      chk("bp_in_ready", 256'(in_ready), 256'(0));
    end
    chk("bp_valid_held", 256'(out_valid), 256'(1));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 256'(out_valid), 256'(0));
    chk("bp_release_idle", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", 256'(in_ready), 256'(0));
    wait_valid(lat);
    chk("bp_second_lat", 256'(lat), 256'(65));
    chk("bp_second_hash", hash_out, ABC_HASH);
    drain();

    // Reset while round 30 is in flight.
    block_i  = ABC_BLK;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_run_busy", 256'(in_ready), 256'(0));
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
    chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
    chk("mid_rst_hash_out", hash_out, 256'h0);
    reset_n = 1'b1;
    send(EMPTY_BLK, lat);
    chk("post_rst_lat", 256'(lat), 256'(65));
    chk("post_rst_hash", hash_out, EMPTY_HASH);
    drain();

`ifdef SHA256_MIDSTATE_EN
    hash_in = IV_C;
    send(TWO_BLK1, lat);
    hash_in = hash_out;
    drain();
    send(TWO_BLK2, lat);
    chk("two_block_hash", hash_out, TWO_HASH);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
